// File: rtl/font_rom_pkg.sv
// Shared font ROM definitions: address/data widths, glyph address helper and read-return tag.
package font_rom_pkg;

    localparam int unsigned FONT_ADDR_W = 11;
    localparam int unsigned FONT_DATA_W = 8;
    localparam int unsigned CHAR_W      = 7;
    localparam int unsigned ROW_W       = 4;
    localparam int unsigned REQ_ID_W    = 3;

    localparam logic [CHAR_W-1:0] BLANK_CHAR = 7'h00;

    // Tracks one issued ROM read on its way back to the requester.
    typedef struct packed {
        logic                valid;
        logic [REQ_ID_W-1:0] id;
    } rd_tag_t;

    function automatic logic [FONT_ADDR_W-1:0] make_font_addr(
        input logic [CHAR_W-1:0] ch,
        input logic [ROW_W-1:0]  row
    );
        return {ch, row};
    endfunction

endpackage

// File: rtl/rr_arbiter_core.sv
// Combinational round-robin winner search starting at ptr and wrapping NREQ-1 -> 0.
module rr_arbiter_core #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  win_onehot_c,
    output logic [IDX_W-1:0] win_idx_c,
    output logic             any_grant_c
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;

    always_comb begin
        win_onehot_c = '0;
        win_idx_c    = '0;
        any_grant_c  = 1'b0;
        sum          = '0;
        cand         = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            // One extra bit keeps ptr+k exact before the explicit wrap for non-power-of-two NREQ.
            sum = {1'b0, ptr} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(NREQ)) begin
                sum = sum - (IDX_W+1)'(NREQ);
            end
            cand = sum[IDX_W-1:0];
            if (!any_grant_c && req[cand]) begin
                any_grant_c        = 1'b1;
                win_idx_c          = cand;
                win_onehot_c[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/font_rom_arbiter.sv
// Round-robin sharing of the synchronous font ROM among text painters; one read per clk,
// read word routed back to its requester ROM_LAT+1 cycles after the grant.
module font_rom_arbiter
    import font_rom_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned ADDR_W  = FONT_ADDR_W,
    parameter int unsigned DATA_W  = FONT_DATA_W,
    parameter int unsigned ROM_LAT = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        rd_valid,
    output logic [DATA_W-1:0]      rd_data,
    output logic [ADDR_W-1:0]      rom_addr,
    input  logic [DATA_W-1:0]      font_word
);

    localparam int unsigned IDX_W = $clog2(NREQ);

    logic [IDX_W-1:0]  ptr;
    logic [NREQ-1:0]   win_onehot_c;
    logic [IDX_W-1:0]  win_idx_c;
    logic              any_grant_c;
    logic [ADDR_W-1:0] addr_arr [NREQ];
    logic [IDX_W-1:0]  next_ptr_c;
    rd_tag_t           issue_tag;
    rd_tag_t           pipe [1:ROM_LAT];

    rr_arbiter_core #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_core (
        .req          (req),
        .ptr          (ptr),
        .win_onehot_c (win_onehot_c),
        .win_idx_c    (win_idx_c),
        .any_grant_c  (any_grant_c)
    );

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
        end
    end

    // Pointer moves one past the winner, wrapping explicitly.
    always_comb begin
        next_ptr_c = ptr;
        if (any_grant_c) begin
            if (win_idx_c == IDX_W'(NREQ - 1)) begin
                next_ptr_c = '0;
            end else begin
                next_ptr_c = win_idx_c + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr       <= '0;
            gnt       <= '0;
            rom_addr  <= '0;
            issue_tag <= '0;
            rd_valid  <= '0;
            rd_data   <= '0;
            for (int unsigned i = 1; i <= ROM_LAT; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            ptr             <= next_ptr_c;
            gnt             <= win_onehot_c;
            issue_tag.valid <= any_grant_c;
            issue_tag.id    <= REQ_ID_W'(win_idx_c);
            if (any_grant_c) begin
                rom_addr <= addr_arr[win_idx_c];
            end

            // issue_tag is the grant-cycle stage; pipe[ROM_LAT] lines up with font_word.
            pipe[1] <= issue_tag;
            for (int unsigned i = 2; i <= ROM_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end

            if (pipe[ROM_LAT].valid) begin
                rd_valid <= NREQ'(1) << pipe[ROM_LAT].id;
                rd_data  <= font_word;
            end else begin
                rd_valid <= '0;
            end
        end
    end

endmodule

// File: tb/tb_font_rom_arbiter.sv
// Directed bench for font_rom_arbiter (NREQ=4, ROM_LAT=1, ROM returns addr[7:0]^8'hA5).
module tb_font_rom_arbiter;
    import font_rom_pkg::*;

    localparam int unsigned NREQ   = 4;
    localparam int unsigned ADDR_W = 11;
    localparam int unsigned DATA_W = 8;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic [NREQ-1:0]        req = '0;
    logic [NREQ*ADDR_W-1:0] req_addr = '0;
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        rd_valid;
    logic [DATA_W-1:0]      rd_data;
    logic [ADDR_W-1:0]      rom_addr;
    logic [DATA_W-1:0]      font_word = '0;

    int n_checks = 0;
    int n_pass   = 0;

    logic [ADDR_W-1:0] addr_tab [NREQ];
    logic [DATA_W-1:0] data_tab [NREQ];

    font_rom_arbiter #(
        .NREQ    (NREQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .ROM_LAT (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_addr  (req_addr),
        .gnt       (gnt),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rom_addr  (rom_addr),
        .font_word (font_word)
    );

    always #5 clk = ~clk;

    // Synchronous font ROM model, one cycle latency.
    always @(posedge clk) font_word <= rom_addr[7:0] ^ 8'hA5;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        addr_tab[0] = make_font_addr(7'h10, 4'h1);  // 11'h101
        addr_tab[1] = make_font_addr(7'h23, 4'h2);  // 11'h232
        addr_tab[2] = make_font_addr(7'h3A, 4'h5);  // 11'h3A5
        addr_tab[3] = make_font_addr(7'h4C, 4'h7);  // 11'h4C7
        data_tab[0] = 8'hA4;
        data_tab[1] = 8'h97;
        data_tab[2] = 8'h00;
        data_tab[3] = 8'h62;
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*ADDR_W +: ADDR_W] = addr_tab[i];
        end

        // Reset held with all requests up
        reset = 1'b1;
        req   = 4'hF;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rst_gnt", 32'(gnt), 32'h0);
            check("rst_rd_valid", 32'(rd_valid), 32'h0);
            check("rst_rom_addr", 32'(rom_addr), 32'h0);
        end

        // Single requester 2
        reset = 1'b0;
        req   = 4'b0100;
        tick();
        check("single_gnt", 32'(gnt), 32'h4);
        check("single_rom_addr", 32'(rom_addr), 32'h3A5);
        req = 4'b0000;
        tick();
        check("single_gnt_off", 32'(gnt), 32'h0);
        check("single_rdv_early", 32'(rd_valid), 32'h0);
        tick();
        check("single_rd_valid", 32'(rd_valid), 32'h4);
        check("single_rd_data", 32'(rd_data), 32'h00);

        // All requesting for 8 cycles after a fresh reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req   = 4'hF;
        for (int c = 0; c < 10; c++) begin
            tick();
            check("all_gnt", 32'(gnt), (c < 8) ? (32'h1 << (c % 4)) : 32'h0);
            if (c < 8) check("all_rom_addr", 32'(rom_addr), 32'(addr_tab[c % 4]));
            if (c >= 2) begin
                check("all_rd_valid", 32'(rd_valid), 32'h1 << ((c - 2) % 4));
                check("all_rd_data", 32'(rd_data), 32'(data_tab[(c - 2) % 4]));
            end else begin
                check("all_rdv_early", 32'(rd_valid), 32'h0);
            end
            if (c == 7) req = 4'h0;
        end

        // Wrap: winner 2 leaves ptr=3, then 4'b1001
        req = 4'b0100;
        tick();
        check("wrap_gnt2", 32'(gnt), 32'h4);
        req = 4'b1001;
        tick();
        check("wrap_gnt3", 32'(gnt), 32'h8);
        tick();
        check("wrap_gnt0", 32'(gnt), 32'h1);
        check("wrap_rd_valid", 32'(rd_valid), 32'h4);
        req = 4'b0000;
        tick();
        check("wrap_idle", 32'(gnt), 32'h0);
        tick();

        // Withdrawn request: req[1] dropped while req[0] keeps winning
        req = 4'b1000;
        tick();
        check("wd_gnt3", 32'(gnt), 32'h8);
        req = 4'b0011;
        tick();
        check("wd_gnt0a", 32'(gnt), 32'h1);
        req = 4'b0001;
        tick();
        check("wd_gnt0b", 32'(gnt), 32'h1);
        check("wd_rdv3", 32'(rd_valid), 32'h8);
        check("wd_rdd3", 32'(rd_data), 32'h62);
        tick();
        check("wd_gnt0c", 32'(gnt), 32'h1);
        check("wd_rdv0", 32'(rd_valid), 32'h1);
        check("wd_rdd0", 32'(rd_data), 32'hA4);
        req = 4'b0000;
        tick();
        check("wd_idle", 32'(gnt), 32'h0);

        // Reset one cycle after a grant discards the read
        req = 4'b0010;
        tick();
        check("rm_gnt1", 32'(gnt), 32'h2);
        reset = 1'b1;
        req   = 4'b0000;
        tick();
        check("rm_gnt", 32'(gnt), 32'h0);
        check("rm_rd_valid", 32'(rd_valid), 32'h0);
        check("rm_rom_addr", 32'(rom_addr), 32'h0);
        check("rm_rd_data", 32'(rd_data), 32'h0);
        tick();
        check("rm_rd_valid2", 32'(rd_valid), 32'h0);
        reset = 1'b0;
        req   = 4'b1010;
        tick();
        check("post_rst_gnt", 32'(gnt), 32'h2);
        check("post_rst_rdv", 32'(rd_valid), 32'h0);
        tick();
        check("post_rst_gnt3", 32'(gnt), 32'h8);
        req = 4'b0000;
        tick();
        check("post_rst_rdv1", 32'(rd_valid), 32'h2);
        check("post_rst_rdd1", 32'(rd_data), 32'h97);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
